imem_dmem_arbiter: RTL

- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Serialises the two ports with fixed data-over-fetch priority, one outstanding transaction at a time.
- Generates the IF and MEM stall signals for the hazard/flush logic.
- Discards in-flight fetches killed by a branch/jump redirect.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/arb_perf_counters.sv | 34 +++
 rtl/imem_dmem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the unified-memory arbiter.
//   - arb_state_t : arbiter FSM states
//   - ARB_AW/ARB_DW/ARB_SW : default address/data/strobe widths
//   - PERF_W : width of the optional performance counters
package pipe_pkg;

  localparam int unsigned ARB_AW = 32;
  localparam int unsigned ARB_DW = 32;
  localparam int unsigned ARB_SW = ARB_DW / 8;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_IF,
    ISSUE_DM,
    WAIT_IF,
    WAIT_DM,
    DROP
  } arb_state_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Optional arbiter performance counters (only built with ARB_PERF_CNT_EN).
//   clk, rst_n      : clock, asynchronous active-low clear
//   if_wait_en      : count a cycle of IF stall
//   dm_wait_en      : count a cycle of MEM stall
//   drop_en         : count a fetch entering DROP
//   if_wait_cnt, dm_wait_cnt, drop_cnt : wrapping W-bit counters
`ifdef ARB_PERF_CNT_EN
module arb_perf_counters #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_wait_en,
  input  logic         dm_wait_en,
  input  logic         drop_en,
  output logic [W-1:0] if_wait_cnt,
  output logic [W-1:0] dm_wait_cnt,
  output logic [W-1:0] drop_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_wait_cnt <= '0;
      dm_wait_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (if_wait_en) if_wait_cnt <= if_wait_cnt + 1'b1;
      if (dm_wait_en) dm_wait_cnt <= dm_wait_cnt + 1'b1;
      if (drop_en)    drop_cnt    <= drop_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch
// (IF) and load/store (MEM). Data has fixed priority over fetch; one
// transaction is outstanding at a time. Fetches killed by a redirect are
// drained in DROP without producing if_valid.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   if_req/if_addr/if_flush          : fetch request, PC, redirect kill
//   if_rdata/if_valid/if_stall       : fetched word, completion pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb : load/store request
//   dm_rdata/dm_valid/dm_stall       : load data, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : registered memory request
//   mem_gnt/mem_rvalid/mem_rdata     : memory accept, response, read data
//   perf_if_wait/perf_dm_wait/perf_drop : counters, only with ARB_PERF_CNT_EN
module imem_dmem_arbiter
  import pipe_pkg::*;
#(
  parameter int unsigned AW = ARB_AW,
  parameter int unsigned DW = ARB_DW,
  parameter int unsigned SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [SW-1:0] dm_wstrb,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [SW-1:0] mem_wstrb,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_if_wait,
  output logic [PERF_W-1:0] perf_dm_wait,
  output logic [PERF_W-1:0] perf_drop
`endif
);

  arb_state_t state;
  // Remembers a flush seen in ISSUE_IF while the grant is still pending,
  // since the redirect pulse may be gone by the time mem_gnt arrives.
  logic       kill;

  logic if_elig;
  logic dm_elig;

  // A port whose valid pulse is high still holds its completed request.
  assign if_elig  = if_req && !if_valid;
  assign dm_elig  = dm_req && !dm_valid;
  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kill      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (dm_elig) begin
            state     <= ISSUE_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
          end else if (if_elig) begin
            state     <= ISSUE_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end
        end
        ISSUE_IF: begin
          if (if_flush) kill <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            kill    <= 1'b0;
            state   <= (if_flush || kill) ? DROP : WAIT_IF;
          end
        end
        ISSUE_DM: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT_DM;
          end
        end
        WAIT_IF: begin
          if (mem_rvalid) begin
            // A flush coinciding with the response discards the data.
            if (!if_flush) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
            state <= IDLE;
          end else if (if_flush) begin
            state <= DROP;
          end
        end
        WAIT_DM: begin
          if (mem_rvalid) begin
            dm_rdata <= mem_rdata;
            dm_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        DROP: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic drop_enter;

  assign drop_enter = ((state == ISSUE_IF) && mem_gnt && (if_flush || kill)) ||
                      ((state == WAIT_IF) && if_flush && !mem_rvalid);

  arb_perf_counters #(
    .W(PERF_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_wait_en  (if_stall),
    .dm_wait_en  (dm_stall),
    .drop_en     (drop_enter),
    .if_wait_cnt (perf_if_wait),
    .dm_wait_cnt (perf_dm_wait),
    .drop_cnt    (perf_drop)
  );
`endif

endmodule
